// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter chain: sample width, sample type, and clog2.
package fir_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Sample-in / decimated-out bundle for fir_decimator; master drives inputs, slave is the decimator.
interface fir_decimator_if
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_W,
    parameter int unsigned FIFO_DEPTH = 4
) ();

    localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;

    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    sync;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        fifo_count;
    logic                    ovf;

    modport master (
        output in_data, in_valid, sync, out_ready,
        input  out_data, out_valid, fifo_count, ovf
    );

    modport slave (
        input  in_data, in_valid, sync, out_ready,
        output out_data, out_valid, fifo_count, ovf
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word and registered flags.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next_c;
    logic [CNT_W-1:0] count_next_c;
    logic             do_push_c;
    logic             do_pop_c;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_c     = 1'b0;
        do_push_c    = 1'b0;
        rd_next_c    = rd_ptr + PTR_W'(1);
        count_next_c = count;
        do_pop_c     = pop & ~empty;
        do_push_c    = push & (~full | do_pop_c);
        count_next_c = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_next_c;
            end
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == '0);
            // Head register: next stored entry on pop, or the incoming word when it becomes the head.
            if (do_pop_c && (count > CNT_W'(1))) begin
                rdata <= mem[rd_next_c];
            end else if (do_push_c && (empty || do_pop_c)) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: averages DECIM valid samples into one result, buffered in an output FIFO.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_W,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    fir_decimator_if.slave   bus
);

    localparam int unsigned LOG2D = clog2(DECIM);
    localparam int unsigned ACC_W = WIDTH + LOG2D;
    localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;

    logic signed [ACC_W-1:0] acc;
    logic [LOG2D-1:0]        phase;
    logic signed [ACC_W-1:0] in_ext_c;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] shifted_c;
    logic [WIDTH-1:0]        result_c;
    logic                    last_c;
    logic                    dump_c;
    logic                    drop_c;
    logic [WIDTH-1:0]        head;
    logic                    full;
    logic                    empty;
    logic [CNT_W-1:0]        count;

    // Sum is one bit-growth wider per halving, so the floor-shifted average always fits WIDTH.
    always_comb begin
        in_ext_c  = '0;
        sum_c     = '0;
        shifted_c = '0;
        result_c  = '0;
        last_c    = 1'b0;
        dump_c    = 1'b0;
        drop_c    = 1'b0;
        in_ext_c  = $signed({{LOG2D{bus.in_data[WIDTH-1]}}, bus.in_data});
        sum_c     = acc + in_ext_c;
        shifted_c = sum_c >>> LOG2D;
        result_c  = shifted_c[WIDTH-1:0];
        last_c    = (phase == LOG2D'(DECIM - 1));
        dump_c    = bus.in_valid & ~bus.sync & last_c;
        drop_c    = dump_c & full & ~bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.sync) begin
            acc   <= '0;
            phase <= '0;
        end else if (bus.in_valid) begin
            if (last_c) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum_c;
                phase <= phase + LOG2D'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ovf <= 1'b0;
        end else if (drop_c) begin
            bus.ovf <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dump_c),
        .wdata (result_c),
        .pop   (bus.out_ready),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.out_data   = $signed(head);
    assign bus.out_valid  = ~empty;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_fir_decimator.sv
// Randomized and directed bench for fir_decimator against an arithmetic averaging/queue reference model.
module tb_fir_decimator;
    import fir_pkg::*;

    localparam int unsigned DECIM = 4;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    fir_decimator_if #(.WIDTH(SAMPLE_W), .FIFO_DEPTH(DEPTH)) bus ();

    fir_decimator #(
        .WIDTH      (SAMPLE_W),
        .DECIM      (DECIM),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: pending group sum/size, expected FIFO contents, sticky overflow.
    int q[$];
    int gsum;
    int gn;
    bit m_ovf;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_avg(input int s);
        int r;
        r = s / int'(DECIM);
        if ((s % int'(DECIM) != 0) && (s < 0)) r = r - 1;
        return r;
    endfunction

    task automatic model(input bit r, input bit v, input int d, input bit s, input bit rdy);
        bit popping;
        bit has;
        int res;
        has = 0;
        res = 0;
        if (r) begin
            q.delete();
            gsum  = 0;
            gn    = 0;
            m_ovf = 0;
            return;
        end
        popping = rdy && (q.size() != 0);
        if (s) begin
            gsum = 0;
            gn   = 0;
        end else if (v) begin
            gsum += d;
            gn++;
            if (gn == int'(DECIM)) begin
                res  = floor_avg(gsum);
                has  = 1;
                gsum = 0;
                gn   = 0;
            end
        end
        if (popping) void'(q.pop_front());
        if (has) begin
            if (q.size() < int'(DEPTH)) q.push_back(res);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_model();
        check("m_valid", int'(bus.out_valid), int'(q.size() != 0));
        check("m_count", int'(bus.fifo_count), q.size());
        check("m_ovf", int'(bus.ovf), int'(m_ovf));
        if (q.size() != 0) check("m_data", int'(bus.out_data), q[0]);
    endtask

    task automatic step(input bit r, input bit v, input int d, input bit s, input bit rdy);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = sample_t'(d);
        bus.sync      = s;
        bus.out_ready = rdy;
        @(posedge clk);
        model(r, v, d, s, rdy);
        #1;
        compare_model();
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 0, 0, 0, 1);
    endtask

    task automatic group(input int val, input bit rdy);
        repeat (DECIM) step(0, 1, val, 0, rdy);
    endtask

    initial begin
        int gv[7];
        int gd[7];
        sample_t r16;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sync      = 1'b0;
        bus.out_ready = 1'b0;
        gsum = 0; gn = 0; m_ovf = 0;

        step(1, 0, 0, 0, 0);
        step(1, 1, 77, 0, 1);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_count", int'(bus.fifo_count), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_data", int'(bus.out_data), 0);

        // Basic average
        for (int i = 0; i < 4; i++) step(0, 1, 4 * (i + 1), 0, 0);
        check("avg_valid", int'(bus.out_valid), 1);
        check("avg_data", int'(bus.out_data), 10);
        check("avg_count", int'(bus.fifo_count), 1);
        drain(1);

        // Floor rounding and extremes
        step(0, 1, -1, 0, 0); step(0, 1, -1, 0, 0); step(0, 1, -1, 0, 0); step(0, 1, -2, 0, 0);
        check("neg_floor", int'(bus.out_data), -2);
        drain(1);
        group(32767, 0);
        check("max_pos", int'(bus.out_data), 32767);
        drain(1);
        group(-32768, 0);
        check("max_neg", int'(bus.out_data), -32768);
        drain(1);

        // Gapped valid
        gv = '{1, 0, 0, 1, 1, 0, 1};
        gd = '{1, 0, 0, 2, 3, 0, 6};
        for (int i = 0; i < 7; i++) begin
            step(0, gv[i][0], gd[i], 0, 0);
            if (i == 5) check("gap_early", int'(bus.out_valid), 0);
        end
        check("gap_valid", int'(bus.out_valid), 1);
        check("gap_data", int'(bus.out_data), 3);
        check("gap_count", int'(bus.fifo_count), 1);
        drain(1);

        // Backpressure overflow
        repeat (5) group(100, 0);
        check("bp_count", int'(bus.fifo_count), 4);
        check("bp_ovf", int'(bus.ovf), 1);
        check("bp_data", int'(bus.out_data), 100);
        drain(4);
        check("bp_empty", int'(bus.out_valid), 0);
        check("bp_ovf_hold", int'(bus.ovf), 1);

        // Full FIFO with pop on dump cycle
        step(1, 0, 0, 0, 0);
        group(10, 0); group(20, 0); group(30, 0); group(40, 0);
        repeat (3) step(0, 1, 50, 0, 0);
        step(0, 1, 50, 0, 1);
        check("fp_count", int'(bus.fifo_count), 4);
        check("fp_ovf", int'(bus.ovf), 0);
        for (int k = 0; k < 4; k++) begin
            check("fp_order", int'(bus.out_data), 20 + 10 * k);
            step(0, 0, 0, 0, 1);
        end
        check("fp_drained", int'(bus.out_valid), 0);

        // sync discards partial group
        step(0, 1, 5, 0, 0); step(0, 1, 5, 0, 0); step(0, 1, 5, 1, 0);
        group(8, 0);
        check("sync_count", int'(bus.fifo_count), 1);
        check("sync_data", int'(bus.out_data), 8);

        // rst mid-group clears FIFO and partial sum
        step(0, 1, 5, 0, 0); step(0, 1, 5, 0, 0); step(1, 1, 5, 0, 0);
        check("mrst_count", int'(bus.fifo_count), 0);
        group(8, 0);
        check("mrst_data", int'(bus.out_data), 8);
        check("mrst_count2", int'(bus.fifo_count), 1);
        check("mrst_ovf", int'(bus.ovf), 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r16 = sample_t'($urandom);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 int'(r16),
                 ($urandom_range(0, 32) == 0),
                 ($urandom_range(0, 9) < (i < 2000 ? 3 : 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the FIR filter. Consumes one filtered sample per valid cycle and decimates by DECIM using integrate-and-dump averaging.
- Buffers the decimated results in a small FIFO and presents them on a valid/ready output interface to the next consumer (DMA/serializer).
- Provides the sample-rate reduction that follows the low-pass FIR.

Parameters:
- WIDTH, 16, sample width (signed two's complement), in and out.
- DECIM, 4, decimation factor. Must be a power of two, 2..64. LOG2D = clog2(DECIM).
- FIFO_DEPTH, 4, output FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  signed filtered sample (FIR registered output).
- in_valid  input  1  in_data valid this cycle. No backpressure: the input is always accepted.
- sync  input  1  resynchronise decimation phase (clears partial group).
- out_data  output  WIDTH  signed decimated sample at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
- ovf  output  1  sticky: a decimated result was dropped because the FIFO was full.

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: phase=0, acc=0, FIFO empty, out_valid=0, out_data=0, fifo_count=0, ovf=0. Reset mid-group discards the partial sum. Reset overrides all other inputs.
- Accumulator: signed, WIDTH+LOG2D bits, so no overflow is possible. in_data is sign-extended before adding.
- Phase counter 0..DECIM-1 advances only on cycles with in_valid=1.
  - in_valid and phase<DECIM-1: acc <= acc + in_data; phase++.
  - in_valid and phase==DECIM-1 ("dump"): result = (acc + in_data) >>> LOG2D (arithmetic shift, floor toward −inf, low WIDTH bits; always in range). Result is pushed to the FIFO, acc <= 0, phase <= 0.
- sync=1: acc <= 0, phase <= 0, and any in_valid sample in the same cycle is discarded. sync has priority over a dump. FIFO contents and ovf are unaffected.
- Latency: a dump at edge t makes the result visible on out_data/out_valid after edge t, provided the FIFO was empty.
- FIFO: synchronous, first-word-fall-through. out_data is the head entry, registered.
  - pop = out_valid & out_ready.
  - A push is accepted if the FIFO is not full, OR if it is full and a pop occurs in the same cycle (count unchanged).
  - Push while full with no pop: the result is dropped and ovf <= 1. ovf holds until rst.
  - Pop on empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count tracks pushes minus pops: 0..FIFO_DEPTH.
- out_data is held stable while out_valid=1 and out_ready=0.
- out_data when empty: holds the last popped value (0 after reset). It is don't-care for checking.

Decomposition:
- Shared package fir_pkg:
  - constant SAMPLE_W = 16;
  - typedef sample_t (signed [SAMPLE_W-1:0]);
  - function clog2.
  - The FIR and this block both use these.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. It is reusable elsewhere in the filter chain. The decimation datapath stays in fir_decimator.

Test Plan:
- DECIM=4, in_valid=1 continuously, in_data 4,8,12,16 → after the 4th edge: out_valid=1, out_data=10, fifo_count=1.
- Negative rounding: in_data −1,−1,−1,−2 → out_data=−2 (sum −5 >>> 2, floor). Then 32767 ×4 → 32767; −32768 ×4 → −32768.
- Gapped input: in_valid pattern 1,0,0,1,1,0,1 with data 1,x,x,2,3,x,6 → exactly one output of 3 (12>>>2), produced on the 7th cycle.
- Backpressure, FIFO_DEPTH=4: out_ready=0, 5 groups of constant 100 → fifo_count=4, ovf=1, four outputs of 100. Then out_ready=1 → 4 pops, out_valid drops, ovf remains 1.
- FIFO full with out_ready=1 on the dump cycle → push accepted, count stays 4, ovf stays 0, output order preserved.
- sync asserted with in_valid on phase 2 (data 5,5,5) → partial group discarded. The next 4 samples of 8 produce 8. A rst mid-group behaves the same, and also clears the FIFO and ovf.
